// File: rtl/divider_restoring_sequential.sv
// divider_restoring_sequential
//
// Multi-cycle unsigned integer divider using the restoring shift-subtract
// algorithm. One quotient bit is retired per clock, so an N-bit division
// takes N cycles after the accepting edge and needs only an (N+1)-bit
// subtractor.
//
// Ports:
//   Clock_In        - single clock, rising edge
//   Reset_In        - asynchronous, active-high reset
//   Start_In        - begin a division (accepted only while idle)
//   Dividend_In     - unsigned dividend, captured on the accepting edge
//   Divisor_In      - unsigned divisor, captured on the accepting edge
//   Quotient_Out    - registered quotient, held until the next completion
//   Remainder_Out   - registered remainder, held until the next completion
//   Busy_Out        - high while an operation is in flight
//   Done_Out        - one-cycle pulse when results become valid
//   Div_By_Zero_Out - set with the results when the divisor was 0
//
// Optional feature: define DIVIDER_ZERO_DETECT_EN to detect a zero divisor on
// the accepting edge and finish one cycle later (Quotient all ones, Remainder
// equal to the dividend, Div_By_Zero_Out set). Without it a zero divisor runs
// the normal N iterations, which naturally give the same Quotient/Remainder,
// and Div_By_Zero_Out is tied low.

module divider_restoring_sequential #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Dividend_In,
  input  logic [DATA_WIDTH-1:0] Divisor_In,
  output logic [DATA_WIDTH-1:0] Quotient_Out,
  output logic [DATA_WIDTH-1:0] Remainder_Out,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic                  Div_By_Zero_Out
);

  localparam int N     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  // Shift register: dividend bits leave at the MSB while quotient bits enter
  // at the LSB, so after N steps it holds the quotient.
  logic [N-1:0]       r_dividend, w_dividend_nxt;
  logic [N-1:0]       r_divisor,  w_divisor_nxt;
  logic [N:0]         r_rem,      w_rem_nxt;
  logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
  logic [N-1:0]       r_quot,     w_quot_nxt;
  logic [N-1:0]       r_remout,   w_remout_nxt;
  logic               r_busy,     w_busy_nxt;
  logic               r_done,     w_done_nxt;

  logic [N:0]         w_shifted;
  logic [N:0]         w_diff;
  logic               w_neg;
  logic [CNT_W-1:0]   w_cnt_dec;
  logic [N-1:0]       w_shift_out;
  logic [N:0]         w_rem_step;

`ifdef DIVIDER_ZERO_DETECT_EN
  logic               r_zero, w_zero_nxt;
  logic               r_dbz,  w_dbz_nxt;
`endif

  // The partial remainder never exceeds the divisor, so its top bit is always
  // 0; it is kept only to match the N+1-bit working width.
  logic               w_unused_rem_msb;
  assign w_unused_rem_msb = r_rem[N];

  // One restoring step: shift in the next dividend bit, trial-subtract.
  // The borrow (bit N of the difference) marks a negative result, which is
  // valid because the shifted value is always below twice the divisor.
  assign w_shifted   = {r_rem[N-1:0], r_dividend[N-1]};
  assign w_diff      = w_shifted - {1'b0, r_divisor};
  assign w_neg       = w_diff[N];
  assign w_rem_step  = w_neg ? w_shifted : w_diff;
  assign w_shift_out = {r_dividend[N-2:0], ~w_neg};
  assign w_cnt_dec   = r_cnt - CNT_W'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_rem_nxt      = r_rem;
    w_cnt_nxt      = r_cnt;
    w_quot_nxt     = r_quot;
    w_remout_nxt   = r_remout;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
`ifdef DIVIDER_ZERO_DETECT_EN
    w_zero_nxt     = r_zero;
    w_dbz_nxt      = r_dbz;
`endif

    case (r_state)
      IDLE: begin
        if (Start_In) begin
          w_dividend_nxt = Dividend_In;
          w_divisor_nxt  = Divisor_In;
          w_rem_nxt      = '0;
          w_cnt_nxt      = CNT_W'(N);
          w_busy_nxt     = 1'b1;
          w_state_nxt    = CALC;
`ifdef DIVIDER_ZERO_DETECT_EN
          w_zero_nxt     = (Divisor_In == '0);
`endif
        end
      end

      CALC: begin
`ifdef DIVIDER_ZERO_DETECT_EN
        if (r_zero) begin
          // Zero divisor: skip iteration and report the saturated result.
          w_quot_nxt   = '1;
          w_remout_nxt = r_dividend;
          w_dbz_nxt    = 1'b1;
          w_cnt_nxt    = '0;
          w_done_nxt   = 1'b1;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = IDLE;
        end else begin
`endif
          w_dividend_nxt = w_shift_out;
          w_rem_nxt      = w_rem_step;
          w_cnt_nxt      = w_cnt_dec;
          // Final step: publish this step's values directly so results are
          // visible right after edge EN.
          if (w_cnt_dec == '0) begin
            w_quot_nxt   = w_shift_out;
            w_remout_nxt = w_rem_step[N-1:0];
            w_done_nxt   = 1'b1;
            w_busy_nxt   = 1'b0;
            w_state_nxt  = IDLE;
`ifdef DIVIDER_ZERO_DETECT_EN
            w_dbz_nxt    = 1'b0;
`endif
          end
`ifdef DIVIDER_ZERO_DETECT_EN
        end
`endif
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      r_state    <= IDLE;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_quot     <= '0;
      r_remout   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef DIVIDER_ZERO_DETECT_EN
      r_zero     <= 1'b0;
      r_dbz      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_rem      <= w_rem_nxt;
      r_cnt      <= w_cnt_nxt;
      r_quot     <= w_quot_nxt;
      r_remout   <= w_remout_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
`ifdef DIVIDER_ZERO_DETECT_EN
      r_zero     <= w_zero_nxt;
      r_dbz      <= w_dbz_nxt;
`endif
    end
  end

  assign Quotient_Out  = r_quot;
  assign Remainder_Out = r_remout;
  assign Busy_Out      = r_busy;
  assign Done_Out      = r_done;

`ifdef DIVIDER_ZERO_DETECT_EN
  assign Div_By_Zero_Out = r_dbz;
`else
  assign Div_By_Zero_Out = 1'b0;
`endif

endmodule
